// File: rtl/alu_sequencer.sv
// Instruction sequencer for the shared combinational ALU: 4-entry register file,
// IDLE/EXEC/WB handshake control, write-back and carry/zero flag generation.
module alu_sequencer #(
    parameter int LEN = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [3:0]     instr_op,
    input  logic [1:0]     instr_rd,
    input  logic [1:0]     instr_rs,
    input  logic [LEN-1:0] instr_imm,
    output logic [LEN-1:0] alu_a,
    output logic [LEN-1:0] alu_b,
    output logic [3:0]     alu_code,
    input  logic [LEN-1:0] alu_result,
    output logic           done,
    output logic           err,
    output logic           flag_c,
    output logic           flag_z,
    input  logic [1:0]     rd_sel,
    output logic [LEN-1:0] rd_data
);
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_SHL   = 4'b0111;
    localparam logic [3:0] OP_SHR   = 4'b1000;
    localparam logic [3:0] OP_LOADI = 4'b1001;
    localparam logic [3:0] OP_MOVE  = 4'b1010;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t         state, state_nx;
    logic [LEN-1:0] regs [4];
    logic [3:0]     op_q;
    logic [1:0]     rd_q;
    logic [LEN-1:0] ldv_q;
    logic           accept;
    logic           wb_alu, div0, wr_en, carry;
    logic [LEN-1:0] wr_val;
    logic [LEN:0]   sum;

    assign accept  = instr_valid && instr_ready;
    assign rd_data = regs[rd_sel];
    assign sum     = {1'b0, alu_a} + {1'b0, alu_b};

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) state_nx = EXEC;
            end
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Write-back decode; alu_a/alu_b still hold the operands of the op being retired.
    always_comb begin
        wb_alu = (op_q <= OP_SHR);
        div0   = (op_q == OP_DIV) && (alu_b == '0);
        wr_en  = 1'b0;
        wr_val = alu_result;
        carry  = 1'b0;
        if (wb_alu) begin
            wr_en = !div0;
        end else if (op_q == OP_LOADI || op_q == OP_MOVE) begin
            wr_en  = 1'b1;
            wr_val = ldv_q;
        end
        case (op_q)
            OP_ADD:  carry = sum[LEN];
            OP_SUB:  carry = (alu_a < alu_b);
            OP_SHL:  carry = alu_a[LEN-1];
            OP_SHR:  carry = alu_a[0];
            default: carry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_code <= 4'b1111;
            op_q     <= 4'b1111;
            rd_q     <= '0;
            ldv_q    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            flag_c   <= 1'b0;
            flag_z   <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            err   <= 1'b0;
            if (accept) begin
                op_q <= instr_op;
                rd_q <= instr_rd;
                if (instr_op <= OP_SHR) begin
                    alu_a    <= regs[instr_rd];
                    alu_b    <= regs[instr_rs];
                    alu_code <= instr_op;
                end else begin
                    ldv_q <= (instr_op == OP_LOADI) ? instr_imm : regs[instr_rs];
                end
            end
            if (state == WB) begin
                done <= 1'b1;
                err  <= wb_alu && div0;
                if (wr_en) begin
                    regs[rd_q] <= wr_val;
                    flag_z     <= (wr_val == '0);
                end
                if (wb_alu && !div0) flag_c <= carry;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer with a behavioural model of the external ALU.
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready;
    logic [3:0] instr_op;
    logic [1:0] instr_rd, instr_rs;
    logic [7:0] instr_imm;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_code;
    logic       done, err, flag_c, flag_z;
    logic [1:0] rd_sel;
    logic [7:0] rd_data;

    int nvec = 0;
    int nbad = 0;

    alu_sequencer #(.LEN(8)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_result(alu_result),
        .done(done), .err(err), .flag_c(flag_c), .flag_z(flag_z),
        .rd_sel(rd_sel), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // External ALU; DIV by zero returns all-ones, which must never be written back.
    always_comb begin
        alu_result = 8'h00;
        case (alu_code)
            4'd0: alu_result = alu_a + alu_b;
            4'd1: alu_result = alu_a - alu_b;
            4'd2: alu_result = alu_a * alu_b;
            4'd3: alu_result = (alu_b == 8'h00) ? 8'hFF : alu_a / alu_b;
            4'd4: alu_result = alu_a ^ alu_b;
            4'd5: alu_result = alu_a & alu_b;
            4'd6: alu_result = alu_a | alu_b;
            4'd7: alu_result = alu_a << alu_b;
            4'd8: alu_result = alu_a >> alu_b;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input logic [1:0] r, input int exp);
        rd_sel = r;
        #1;
        chk($sformatf("R%0d", r), 32'(rd_data), exp);
    endtask

    // Issue one instruction and follow it to retirement; returns 1 ns after the done edge.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, input logic exp_err);
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(instr_ready), 1);
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("exec_ready", 32'(instr_ready), 0);
        chk("exec_done", 32'(done), 0);
        if (op <= 4'd8) chk("alu_code", 32'(alu_code), 32'(op));
        @(posedge clk); #1;
        chk("wb_ready", 32'(instr_ready), 0);
        chk("wb_done", 32'(done), 0);
        @(posedge clk); #1;
        chk("done", 32'(done), 1);
        chk("err", 32'(err), 32'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] imms [3];
        int idx, last, ndone;
        logic prevdone, acc;
        imms = '{8'h11, 8'h22, 8'h33};

        rst = 1'b1; instr_valid = 1'b0; instr_op = 4'h0; instr_rd = 2'd0;
        instr_rs = 2'd0; instr_imm = 8'h00; rd_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(instr_ready), 1);
        chk("rst_code", 32'(alu_code), 32'hF);
        chk("rst_a", 32'(alu_a), 0);
        chk("rst_b", 32'(alu_b), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_flags", 32'({flag_c, flag_z}), 0);
        rst = 1'b0;
        rchk(2'd0, 0);
        rchk(2'd3, 0);

        // ADD with carry out to zero
        issue(4'h9, 2'd0, 2'd0, 8'hFF, 1'b0);
        chk("loadi_z", 32'(flag_z), 0);
        issue(4'h9, 2'd1, 2'd0, 8'h01, 1'b0);
        issue(4'h0, 2'd0, 2'd1, 8'h00, 1'b0);
        chk("add_a", 32'(alu_a), 32'hFF);
        chk("add_b", 32'(alu_b), 32'h01);
        chk("add_c", 32'(flag_c), 1);
        chk("add_z", 32'(flag_z), 1);
        rchk(2'd0, 8'h00);

        // SUB borrow, SHR shifted-out bit
        issue(4'h9, 2'd2, 2'd0, 8'h05, 1'b0);
        issue(4'h9, 2'd3, 2'd0, 8'h07, 1'b0);
        issue(4'h1, 2'd2, 2'd3, 8'h00, 1'b0);
        chk("sub_c", 32'(flag_c), 1);
        chk("sub_z", 32'(flag_z), 0);
        rchk(2'd2, 8'hFE);
        issue(4'h8, 2'd3, 2'd1, 8'h00, 1'b0);
        chk("shr_c", 32'(flag_c), 1);
        rchk(2'd3, 8'h03);

        // DIV by zero suppressed, then truncating MUL
        issue(4'h9, 2'd1, 2'd0, 8'h10, 1'b0);
        issue(4'h9, 2'd2, 2'd0, 8'h00, 1'b0);
        chk("loadi0_z", 32'(flag_z), 1);
        issue(4'h3, 2'd1, 2'd2, 8'h00, 1'b1);
        chk("div0_flags", 32'({flag_c, flag_z}), 32'b11);
        rchk(2'd1, 8'h10);
        issue(4'h9, 2'd2, 2'd0, 8'h20, 1'b0);
        issue(4'h2, 2'd1, 2'd2, 8'h00, 1'b0);
        chk("mul_c", 32'(flag_c), 0);
        chk("mul_z", 32'(flag_z), 1);
        rchk(2'd1, 8'h00);

        // rd == rs, MOVE, SHL carry
        issue(4'h0, 2'd2, 2'd2, 8'h00, 1'b0);
        chk("same_a", 32'(alu_a), 32'h20);
        chk("same_b", 32'(alu_b), 32'h20);
        rchk(2'd2, 8'h40);
        issue(4'hA, 2'd3, 2'd2, 8'h00, 1'b0);
        rchk(2'd3, 8'h40);
        chk("move_code", 32'(alu_code), 0);
        issue(4'h9, 2'd0, 2'd0, 8'h01, 1'b0);
        issue(4'h9, 2'd3, 2'd0, 8'h81, 1'b0);
        issue(4'h7, 2'd3, 2'd0, 8'h00, 1'b0);
        chk("shl_c", 32'(flag_c), 1);
        chk("shl_z", 32'(flag_z), 0);
        rchk(2'd3, 8'h02);

        // NOP leaves everything alone
        issue(4'hF, 2'd1, 2'd2, 8'hAA, 1'b0);
        chk("nop_code", 32'(alu_code), 32'h7);
        chk("nop_flags", 32'({flag_c, flag_z}), 32'b10);
        rchk(2'd0, 8'h01);
        rchk(2'd1, 8'h00);
        rchk(2'd2, 8'h40);
        rchk(2'd3, 8'h02);

        // instr_valid held high across three LOADIs
        @(posedge clk); #1;
        instr_op = 4'h9; instr_valid = 1'b1;
        idx = 0; last = -10; ndone = 0; prevdone = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            acc = instr_ready && (idx < 3);
            if (idx < 3) begin
                instr_rd  = idx[1:0];
                instr_imm = imms[idx];
            end
            @(posedge clk); #1;
            if (done) ndone++;
            chk("done_pulse", 32'(done && prevdone), 0);
            prevdone = done;
            if (acc) begin
                chk("q_ready_low", 32'(instr_ready), 0);
                chk("acc_gap", 32'((cyc - last) >= 2), 1);
                last = cyc;
                idx++;
                if (idx == 3) instr_valid = 1'b0;
            end
        end
        chk("q_accepts", idx, 3);
        chk("q_dones", ndone, 3);
        rchk(2'd0, 8'h11);
        rchk(2'd1, 8'h22);
        rchk(2'd2, 8'h33);

        // Reset during EXEC of an ADD
        @(posedge clk); #1;
        instr_op = 4'h0; instr_rd = 2'd0; instr_rs = 2'd1; instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        rst = 1'b1;
        chk("mid_exec_ready", 32'(instr_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_done", 32'(done), 0);
        chk("mid_ready", 32'(instr_ready), 1);
        chk("mid_code", 32'(alu_code), 32'hF);
        chk("mid_flags", 32'({flag_c, flag_z}), 0);
        rchk(2'd0, 0);
        rchk(2'd1, 0);
        @(posedge clk); #1;
        chk("mid_done2", 32'(done), 0);
        rchk(2'd0, 0);
        rchk(2'd2, 0);
        rchk(2'd3, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
